// File: rtl/fused_buf_pkg.sv
// rtl/fused_buf_pkg.sv - shared widths, types and occupancy states for the fused buffer path
package fused_buf_pkg;

  localparam int FUSED_WORD_W = 32;
  localparam int FUSED_WORDS  = 4;
  localparam int FUSED_LINE_W = FUSED_WORD_W * FUSED_WORDS;

  typedef logic [FUSED_WORD_W-1:0] fused_word_t;
  typedef logic [FUSED_LINE_W-1:0] fused_line_t;
  typedef logic [1:0]              fused_idx_t;

  // Occupancy of the active/pending line pair; (act=0, pend=1) has no encoding.
  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_BUSY  = 2'd1,
    OCC_FULL  = 2'd2
  } fused_occ_e;

endpackage

// File: rtl/fused_word_unpacker.sv
// rtl/fused_word_unpacker.sv - splits wide fused-buffer lines into words, LSW first
module fused_word_unpacker
  import fused_buf_pkg::*;
#(
  parameter int WORD_W = FUSED_WORD_W,
  parameter int WORDS  = FUSED_WORDS,
  parameter int IDX_W  = $clog2(WORDS)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [WORD_W*WORDS-1:0] data_in,
  input  logic                    valid_in,
  output logic                    ready_in,
  output logic [WORD_W-1:0]       data_out,
  output logic                    valid_out,
  input  logic                    ready_out,
  output logic [IDX_W-1:0]        word_idx,
  output logic                    last_out
);

  localparam int LINE_W = WORD_W * WORDS;

  fused_occ_e        r_occ;
  logic [LINE_W-1:0] r_act_line;
  logic [LINE_W-1:0] r_pend_line;
  logic [IDX_W-1:0]  r_cnt;

  fused_occ_e        w_occ_nxt;
  logic [LINE_W-1:0] w_act_nxt;
  logic [LINE_W-1:0] w_pend_nxt;
  logic [IDX_W-1:0]  w_cnt_nxt;
  logic              w_act_v;
  logic              w_pend_v;
  logic              w_acc_in;
  logic              w_xfer;
  logic              w_fin;

  assign w_act_v  = (r_occ != OCC_EMPTY);
  assign w_pend_v = (r_occ == OCC_FULL);

  assign ready_in  = ~w_pend_v;
  assign valid_out = w_act_v;
  assign word_idx  = r_cnt;
  assign last_out  = w_act_v & (r_cnt == IDX_W'(WORDS-1));
  assign data_out  = w_act_v ? r_act_line[r_cnt*WORD_W +: WORD_W] : '0;

  assign w_acc_in = valid_in & ready_in;
  assign w_xfer   = valid_out & ready_out;
  assign w_fin    = w_xfer & last_out;

  always_comb begin
    w_occ_nxt  = r_occ;
    w_act_nxt  = r_act_line;
    w_pend_nxt = r_pend_line;
    w_cnt_nxt  = r_cnt;
    unique case (r_occ)
      OCC_EMPTY: begin
        if (w_acc_in) begin
          w_act_nxt = data_in;
          w_cnt_nxt = '0;
          w_occ_nxt = OCC_BUSY;
        end
      end
      OCC_BUSY: begin
        if (w_fin) begin
          // Loading straight into the active slot keeps the word stream gapless.
          w_cnt_nxt = '0;
          if (w_acc_in) begin
            w_act_nxt = data_in;
          end else begin
            w_occ_nxt = OCC_EMPTY;
          end
        end else begin
          if (w_xfer) begin
            w_cnt_nxt = r_cnt + IDX_W'(1);
          end
          if (w_acc_in) begin
            w_pend_nxt = data_in;
            w_occ_nxt  = OCC_FULL;
          end
        end
      end
      OCC_FULL: begin
        if (w_fin) begin
          w_act_nxt = r_pend_line;
          w_cnt_nxt = '0;
          w_occ_nxt = OCC_BUSY;
        end else if (w_xfer) begin
          w_cnt_nxt = r_cnt + IDX_W'(1);
        end
      end
      default: begin
        w_occ_nxt = OCC_EMPTY;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_occ       <= OCC_EMPTY;
      r_act_line  <= '0;
      r_pend_line <= '0;
      r_cnt       <= '0;
    end else begin
      r_occ       <= w_occ_nxt;
      r_act_line  <= w_act_nxt;
      r_pend_line <= w_pend_nxt;
      r_cnt       <= w_cnt_nxt;
    end
  end

endmodule

// File: tb/tb_fused_word_unpacker.sv
// tb/tb_fused_word_unpacker.sv - directed and round-trip bench for fused_word_unpacker
module tb_fused_word_unpacker;

  logic         clk;
  logic         reset;
  logic [127:0] data_in;
  logic         valid_in;
  logic         ready_in;
  logic [31:0]  data_out;
  logic         valid_out;
  logic         ready_out;
  logic [1:0]   word_idx;
  logic         last_out;

  int n_pass;
  int n_total;
  int n_illegal;

  fused_word_unpacker dut (
    .clk       (clk),
    .reset     (reset),
    .data_in   (data_in),
    .valid_in  (valid_in),
    .ready_in  (ready_in),
    .data_out  (data_out),
    .valid_out (valid_out),
    .ready_out (ready_out),
    .word_idx  (word_idx),
    .last_out  (last_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pending occupied with active empty would show as valid_out=0 and ready_in=0.
  always @(negedge clk) begin
    if (!reset && !valid_out && !ready_in) n_illegal++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; valid_in = 1'b0; data_in = '0; ready_out = 1'b0;
    step(); step();
    reset = 1'b0;
    n_total++;
    if (valid_out !== 1'b0) $display("FAIL reset_valid_out got %b want 0", valid_out); else n_pass++;
    n_total++;
    if (ready_in !== 1'b1) $display("FAIL reset_ready_in got %b want 1", ready_in); else n_pass++;
    n_total++;
    if (data_out !== 32'h0) $display("FAIL reset_data_out got %h want 0", data_out); else n_pass++;
    n_total++;
    if (word_idx !== 2'd0) $display("FAIL reset_word_idx got %0d want 0", word_idx); else n_pass++;
    n_total++;
    if (last_out !== 1'b0) $display("FAIL reset_last_out got %b want 0", last_out); else n_pass++;
  endtask

  task automatic test_single_line();
    logic [31:0] exp_w [4];
    exp_w[0] = 32'h11111111; exp_w[1] = 32'h22222222;
    exp_w[2] = 32'h33333333; exp_w[3] = 32'h44444444;
    ready_out = 1'b1;
    valid_in = 1'b1;
    data_in = 128'h44444444_33333333_22222222_11111111;
    step();
    valid_in = 1'b0;
    for (int k = 0; k < 4; k++) begin
      n_total++;
      if (valid_out !== 1'b1 || data_out !== exp_w[k])
        $display("FAIL single_word%0d got v=%b %h want v=1 %h", k, valid_out, data_out, exp_w[k]);
      else n_pass++;
      n_total++;
      if (word_idx !== 2'(k)) $display("FAIL single_idx%0d got %0d want %0d", k, word_idx, k); else n_pass++;
      n_total++;
      if (last_out !== (k == 3)) $display("FAIL single_last%0d got %b want %b", k, last_out, (k == 3)); else n_pass++;
      step();
    end
    n_total++;
    if (valid_out !== 1'b0) $display("FAIL single_idle got %b want 0", valid_out); else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_q [$];
    logic [127:0] lines [3];
    int sent, rx, gaps, saw_ready_low, acc;
    for (int l = 0; l < 3; l++) begin
      for (int k = 0; k < 4; k++) begin
        lines[l][k*32 +: 32] = 32'hB000_0000 | (l << 8) | k;
        exp_q.push_back(32'hB000_0000 | (l << 8) | k);
      end
    end
    sent = 0; rx = 0; gaps = 0; saw_ready_low = 0;
    ready_out = 1'b1;
    for (int cyc = 0; cyc < 40 && rx < 12; cyc++) begin
      valid_in = (sent < 3);
      data_in  = (sent < 3) ? lines[sent] : '0;
      acc = valid_in && ready_in;
      if (valid_in && !ready_in) saw_ready_low = 1;
      if (valid_out) begin
        n_total++;
        if (data_out !== exp_q[rx]) $display("FAIL b2b_word%0d got %h want %h", rx, data_out, exp_q[rx]);
        else n_pass++;
        rx++;
      end else if (cyc > 0) begin
        gaps++;
      end
      step();
      if (acc) sent++;
    end
    valid_in = 1'b0;
    n_total++;
    if (rx !== 12) $display("FAIL b2b_count got %0d want 12", rx); else n_pass++;
    n_total++;
    if (gaps !== 0) $display("FAIL b2b_gaps got %0d want 0", gaps); else n_pass++;
    n_total++;
    if (saw_ready_low !== 1) $display("FAIL b2b_ready_low got %0d want 1", saw_ready_low); else n_pass++;
    step(); step();
  endtask

  task automatic test_backpressure();
    logic [31:0] exp_seq [6];
    logic [127:0] line_a, line_b;
    line_a = 128'hA3A3A3A3_A2A2A2A2_A1A1A1A1_A0A0A0A0;
    line_b = 128'hB3B3B3B3_B2B2B2B2_B1B1B1B1_B0B0B0B0;
    exp_seq[0] = 32'hA2A2A2A2; exp_seq[1] = 32'hA3A3A3A3; exp_seq[2] = 32'hB0B0B0B0;
    exp_seq[3] = 32'hB1B1B1B1; exp_seq[4] = 32'hB2B2B2B2; exp_seq[5] = 32'hB3B3B3B3;
    ready_out = 1'b1;
    valid_in = 1'b1; data_in = line_a;
    step();
    valid_in = 1'b0;
    step();
    step();
    ready_out = 1'b0;
    valid_in = 1'b1; data_in = line_b;
    for (int i = 0; i < 5; i++) begin
      n_total++;
      if (data_out !== 32'hA2A2A2A2 || word_idx !== 2'd2)
        $display("FAIL bp_hold%0d got %h idx %0d want a2a2a2a2 idx 2", i, data_out, word_idx);
      else n_pass++;
      if (i > 0) begin
        n_total++;
        if (ready_in !== 1'b0) $display("FAIL bp_ready_in%0d got %b want 0", i, ready_in); else n_pass++;
      end
      step();
      valid_in = 1'b0;
      data_in = 'x;
    end
    ready_out = 1'b1;
    for (int i = 0; i < 6; i++) begin
      n_total++;
      if (valid_out !== 1'b1 || data_out !== exp_seq[i])
        $display("FAIL bp_release%0d got v=%b %h want v=1 %h", i, valid_out, data_out, exp_seq[i]);
      else n_pass++;
      step();
    end
    n_total++;
    if (valid_out !== 1'b0) $display("FAIL bp_idle got %b want 0", valid_out); else n_pass++;
  endtask

  task automatic test_bypass();
    logic [31:0] exp_seq [8];
    for (int k = 0; k < 4; k++) begin
      exp_seq[k]     = 32'hC000_0000 | k;
      exp_seq[k + 4] = 32'hD000_0000 | k;
    end
    ready_out = 1'b1;
    valid_in = 1'b1;
    data_in = {32'hC0000003, 32'hC0000002, 32'hC0000001, 32'hC0000000};
    step();
    valid_in = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (i == 3) begin
        n_total++;
        if (last_out !== 1'b1 || ready_in !== 1'b1)
          $display("FAIL byp_last got last=%b rdy=%b want 1 1", last_out, ready_in);
        else n_pass++;
        valid_in = 1'b1;
        data_in = {32'hD0000003, 32'hD0000002, 32'hD0000001, 32'hD0000000};
      end
      n_total++;
      if (valid_out !== 1'b1 || data_out !== exp_seq[i] || word_idx !== 2'(i % 4))
        $display("FAIL byp_word%0d got v=%b %h idx %0d want v=1 %h idx %0d",
                 i, valid_out, data_out, word_idx, exp_seq[i], i % 4);
      else n_pass++;
      step();
      valid_in = 1'b0;
    end
    n_total++;
    if (valid_out !== 1'b0) $display("FAIL byp_idle got %b want 0", valid_out); else n_pass++;
  endtask

  task automatic test_reset_mid();
    ready_out = 1'b1;
    valid_in = 1'b1; data_in = {4{32'hE0E0E0E0}};
    step();
    valid_in = 1'b1; data_in = {4{32'hF0F0F0F0}};
    step();
    valid_in = 1'b0;
    n_total++;
    if (word_idx !== 2'd1 || ready_in !== 1'b0)
      $display("FAIL rst_mid_pre got idx %0d rdy %b want idx 1 rdy 0", word_idx, ready_in);
    else n_pass++;
    reset = 1'b1;
    step();
    reset = 1'b0;
    n_total++;
    if (valid_out !== 1'b0 || ready_in !== 1'b1 || word_idx !== 2'd0)
      $display("FAIL rst_mid_post got v=%b rdy=%b idx=%0d want 0 1 0", valid_out, ready_in, word_idx);
    else n_pass++;
    valid_in = 1'b1; data_in = 128'h1C1C1C1C_1B1B1B1B_1A1A1A1A_19191919;
    step();
    valid_in = 1'b0;
    n_total++;
    if (valid_out !== 1'b1 || data_out !== 32'h19191919 || word_idx !== 2'd0)
      $display("FAIL rst_mid_fresh got v=%b %h idx %0d want v=1 19191919 idx 0", valid_out, data_out, word_idx);
    else n_pass++;
    for (int i = 0; i < 4; i++) step();
  endtask

  task automatic test_round_trip();
    logic [31:0]  stream [$];
    logic [127:0] line_q [$];
    logic [127:0] pack;
    int rx, lasts, acc, xfer, bad;
    for (int i = 0; i < 32; i++) begin
      stream.push_back($urandom);
      pack[(i % 4)*32 +: 32] = stream[i];
      if (i % 4 == 3) line_q.push_back(pack);
    end
    rx = 0; lasts = 0; bad = 0;
    for (int cyc = 0; cyc < 1000 && rx < 32; cyc++) begin
      ready_out = 1'($urandom_range(0, 1));
      valid_in  = (line_q.size() > 0) && ($urandom_range(0, 3) != 0);
      data_in   = (line_q.size() > 0) ? line_q[0] : 'x;
      acc  = valid_in && ready_in;
      xfer = valid_out && ready_out;
      if (xfer) begin
        if (data_out !== stream[rx]) begin
          bad++;
          $display("FAIL rt_word%0d got %h want %h", rx, data_out, stream[rx]);
        end
        if (last_out) lasts++;
        rx++;
      end
      step();
      if (acc) void'(line_q.pop_front());
    end
    valid_in = 1'b0;
    n_total++;
    if (rx !== 32) $display("FAIL rt_count got %0d want 32", rx); else n_pass++;
    n_total++;
    if (bad !== 0) $display("FAIL rt_data got %0d bad words want 0", bad); else n_pass++;
    n_total++;
    if (lasts !== 8) $display("FAIL rt_lasts got %0d want 8", lasts); else n_pass++;
    n_total++;
    if (n_illegal !== 0) $display("FAIL occupancy_illegal got %0d want 0", n_illegal); else n_pass++;
  endtask

  initial begin
    n_pass = 0; n_total = 0; n_illegal = 0;
    reset = 1'b1; valid_in = 1'b0; data_in = '0; ready_out = 1'b0;
    test_reset();
    test_single_line();
    test_back_to_back();
    test_backpressure();
    test_bypass();
    test_reset_mid();
    test_round_trip();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
